vectorsum_stream_ctrl: RTL and testbench
========================================

// Module: vectorsum_stream_ctrl
// PURPOSE
//  Streaming sequencer wrapped around vectorsum_top: accepts (x,y) element pairs on a valid/ready input,
//  writes them into the x/y BRAM write ports, pulses start, waits for done, then reads z and emits
//  VECTOR_SIZE results on a valid/ready output. Frames repeat back-to-back; one frame = VECTOR_SIZE elements.
// PARAMETERS
//  DATA_WIDTH   32    element width of x, y, z
//  ADDR_WIDTH   10    BRAM address width; VECTOR_SIZE <= 2**ADDR_WIDTH
//  VECTOR_SIZE  1024  elements per frame (>=1)
// PORTS
//  clock      in   1           single clock, rising edge
//  reset      in   1           synchronous, active-high
//  in_valid   in   1           input pair valid
//  in_ready   out  1           ctrl can accept pair
//  in_x       in   DATA_WIDTH  x element
//  in_y       in   DATA_WIDTH  y element
//  out_valid  out  1           out_data valid
//  out_ready  in   1           downstream accepts
//  out_data   out  DATA_WIDTH  z element
//  start      out  1           to vectorsum_top.start, 1-cycle pulse
//  done       in   1           from vectorsum_top.done
//  x_din / y_din          out  DATA_WIDTH  BRAM write data
//  x_wr_addr / y_wr_addr  out  ADDR_WIDTH  BRAM write address (same value)
//  x_wr_en / y_wr_en      out  1           BRAM write enables (same value)
//  z_rd_addr  out  ADDR_WIDTH  z BRAM read address
//  z_dout     in   DATA_WIDTH  z BRAM read data, valid 1 cycle after z_rd_addr
// BEHAVIOUR
//  Reset: state=LOAD, counters=0; in_ready=1(comb. in LOAD), out_valid=0, start=0, wr_en=0,
//   z_rd_addr=0, out_data=0. Reset in any state aborts the frame; no start pulse afterwards.
//  States: LOAD -> KICK -> WAIT -> RD -> OUT -> (RD | LOAD).
//  LOAD: in_ready=1. On in_valid&in_ready: x/y_wr_en=1 same cycle (combinational), addr=wr_cnt,
//   din=in_x/in_y; wr_cnt++. When handshake occurs with wr_cnt==VECTOR_SIZE-1: wr_cnt<=0, ->KICK.
//  KICK: start=1 exactly one cycle; in_ready=0; ->WAIT.
//  WAIT: done ignored on first WAIT cycle (stale-done guard); thereafter done=1 -> RD, rd_cnt=0.
//  RD: z_rd_addr=rd_cnt (registered, held through OUT); one cycle for BRAM latency; ->OUT,
//   out_data<=z_dout captured on RD->OUT edge... i.e. out_data loaded on first OUT cycle from z_dout.
//  OUT: out_valid=1, out_data stable until out_valid&out_ready. On handshake: if
//   rd_cnt==VECTOR_SIZE-1 -> LOAD, rd_cnt<=0; else rd_cnt++, ->RD. Throughput 1 result / 2 cycles min.
//  in_ready=0 in every state except LOAD; input is never accepted while computing or draining.
//  out_valid falls the cycle after the accepting handshake; never drops without handshake.
//  Counters are ADDR_WIDTH+1 bits internally so VECTOR_SIZE==2**ADDR_WIDTH terminates correctly.
//  Latency start->first out_valid: (cycles until done) + 1 WAIT guard + 2 (RD, OUT).
//  No arithmetic here; data passes through unmodified.
// TESTING
//  VECTOR_SIZE=8: stream x=i, y=10*i (i=0..7), out_ready=1 -> out 0,11,22,...,77 in order; 1 start pulse.
//  in_valid toggled every other cycle during LOAD -> exactly 8 writes, addrs 0..7 contiguous, no gaps/duplicates.
//  out_ready low for 5 cycles on element 3 -> out_valid held, out_data=33 stable, no skip.
//  Two frames back-to-back (second with x=100+i, y=0) -> second output 100..107; start pulses exactly twice.
//  done held high from before start -> start still pulses once; output not emitted before WAIT guard.
//  reset asserted in WAIT and in OUT -> next cycle in_ready=1, out_valid=0, start never pulses.

Source files
------------

// File: rtl/vectorsum_stream_ctrl.sv
// Streaming sequencer around vectorsum_top: loads one frame of (x,y) pairs into the
// x/y BRAMs, kicks the core, waits for done, then streams the z results out.
module vectorsum_stream_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int VECTOR_SIZE = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  start,
    input  logic                  done,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic                  x_wr_en,
    output logic                  y_wr_en,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic [2:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the sender holds valid and data stable until then, and ready never depends on valid.

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_KICK = 3'd1,
        S_WAIT = 3'd2,
        S_RD   = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // One extra counter bit so a frame of exactly 2**ADDR_WIDTH elements still terminates.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(VECTOR_SIZE - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic                  guard_q, guard_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  in_hs;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_LOAD;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            guard_q    <= 1'b0;
            first_q    <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            guard_q    <= guard_d;
            first_q    <= first_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        guard_d    = 1'b0;
        first_d    = 1'b0;
        out_data_d = out_data_q;
        in_hs      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        start      = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                in_hs    = in_valid;
                if (in_valid) begin
                    if (wr_cnt_q == LAST) begin
                        wr_cnt_d = '0;
                        state_d  = S_KICK;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_KICK: begin
                start   = 1'b1;
                guard_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done may still be high from the previous frame on the first WAIT cycle.
                if (!guard_q && done) begin
                    rd_cnt_d = '0;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                first_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (first_q) begin
                    out_data_d = z_dout;
                end
                if (out_ready) begin
                    if (rd_cnt_q == LAST) begin
                        rd_cnt_d = '0;
                        state_d  = S_LOAD;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        state_d  = S_RD;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // BRAM data arrives on the first OUT cycle; it is latched then so out_data stays put while stalled.
    assign out_data  = first_q ? z_dout : out_data_q;

    assign x_wr_en   = in_hs;
    assign y_wr_en   = in_hs;
    assign x_wr_addr = wr_cnt_q[ADDR_WIDTH-1:0];
    assign y_wr_addr = wr_cnt_q[ADDR_WIDTH-1:0];
    assign x_din     = in_x;
    assign y_din     = in_y;
    assign z_rd_addr = rd_cnt_q[ADDR_WIDTH-1:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vectorsum_stream_ctrl.sv
// Bench for vectorsum_stream_ctrl: BRAM and vectorsum core models, frame table,
// hand-written reset/back-to-back sequences and randomized frames against a queue model.
`timescale 1ns/1ps
module tb_vectorsum_stream_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int N  = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_x = '0;
    logic [DW-1:0] in_y = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          start;
    logic          done;
    logic [DW-1:0] x_din, y_din;
    logic [AW-1:0] x_wr_addr, y_wr_addr;
    logic          x_wr_en, y_wr_en;
    logic [AW-1:0] z_rd_addr;
    logic [DW-1:0] z_dout = '0;
    logic [2:0]    dbg_state;

    vectorsum_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(N)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .start(start), .done(done),
        .x_din(x_din), .y_din(y_din), .x_wr_addr(x_wr_addr), .y_wr_addr(y_wr_addr),
        .x_wr_en(x_wr_en), .y_wr_en(y_wr_en),
        .z_rd_addr(z_rd_addr), .z_dout(z_dout), .dbg_state(dbg_state)
    );

    // ---------------- BRAMs and core model ----------------
    logic [DW-1:0] x_mem [N];
    logic [DW-1:0] y_mem [N];
    logic [DW-1:0] z_mem [N];
    int   done_lat   = 3;
    logic stale_done = 1'b0;
    int   dly        = 0;

    always @(posedge clock) begin
        if (x_wr_en) x_mem[x_wr_addr] <= x_din;
        if (y_wr_en) y_mem[y_wr_addr] <= y_din;
        z_dout <= z_mem[z_rd_addr];
        if (start) begin
            for (int i = 0; i < N; i++) z_mem[i] <= x_mem[i] + y_mem[i];
            dly <= done_lat;
        end else if (dly > 0) begin
            dly <= dly - 1;
        end
    end
    // done pulses done_lat cycles after the start cycle; stale_done holds it high.
    assign done = (dly == 1) | stale_done;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    int cyc = 0;
    always @(posedge clock) cyc++;

    int start_cnt = 0, wr_total = 0, wr_idx = 0, out_idx = 0, wait_cycles = 0;
    int start_cyc = 0, last_lat = -1;
    bit lat_armed = 0, busy = 0, prev_hs = 0, prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] got [N];

    always @(negedge clock) begin
        if (reset) begin
            wr_idx = 0; out_idx = 0; busy = 0; prev_hs = 0; prev_stall = 0; lat_armed = 0;
        end else begin
            if (start) begin
                start_cnt++; start_cyc = cyc; lat_armed = 1;
            end
            if (lat_armed && out_valid) begin
                last_lat = cyc - start_cyc; lat_armed = 0;
            end
            if ((in_valid && in_ready) || x_wr_en) begin
                check("wr_en", x_wr_en, in_valid && in_ready);
                check("y_wr_en", y_wr_en, in_valid && in_ready);
                check("x_wr_addr", x_wr_addr, wr_idx);
                check("y_wr_addr", y_wr_addr, wr_idx);
                check("x_din", x_din, in_x);
                check("y_din", y_din, in_y);
                wr_total++;
                wr_idx = (wr_idx + 1) % N;
                if (wr_idx == 0) busy = 1;
            end else if (busy) begin
                check("in_ready_busy", in_ready, 0);
            end
            if (prev_hs) check("valid_drop", out_valid, 0);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            prev_hs    = out_valid && out_ready;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (prev_stall) wait_cycles++;
            if (out_valid && out_ready) begin
                got[out_idx] = out_data;
                if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                else check("out_data", out_data, exp_q.pop_front());
                out_idx = (out_idx + 1) % N;
                if (out_idx == 0) busy = 0;
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int stall_at   = -1;
    int stall_left = 0;

    always @(posedge clock) begin
        #1;
        if (ready_mode == 2) out_ready = 1'b0;
        else if (stall_left > 0 && out_valid && out_idx == stall_at) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
    end

    // ---------------- driver tasks ----------------
    logic [DW-1:0] fx [N];
    logic [DW-1:0] fy [N];

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_pair(input logic [DW-1:0] x, input logic [DW-1:0] y);
        bit hs;
        int budget;
        hs = 0; budget = 0;
        in_valid = 1'b1; in_x = x; in_y = y;
        do begin
            @(negedge clock);
            hs = in_ready;
            @(posedge clock);
            #1;
            budget++;
        end while (!hs && budget < 500);
        if (!hs) check("in_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // gap < 0 selects a random gap of 0..2 idle cycles after each pair.
    task automatic send_frame(input int gap);
        int g;
        for (int i = 0; i < N; i++) exp_q.push_back(fx[i] + fy[i]);
        for (int i = 0; i < N; i++) begin
            push_pair(fx[i], fy[i]);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (g > 0) tick(g);
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 2000) begin
            tick(1);
            budget++;
        end
        check("drain_timeout", budget < 2000, 1);
        tick(2);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_wr_en"}, x_wr_en, 0);
        check({tag, "_z_rd_addr"}, z_rd_addr, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        logic [DW-1:0] x_base, x_mul, y_base, y_mul;
        int            gap, stall_at, stall_len, dlat;
        bit            stale;
        logic [DW-1:0] exp_first, exp_last;
        int            exp_lat;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, b;
        tbl[0] = '{0,   1, 0, 10, 0, -1, 0, 3, 0, 0,   77,  5};
        tbl[1] = '{0,   1, 0, 10, 1, -1, 0, 2, 0, 0,   77,  4};
        tbl[2] = '{0,   1, 0, 10, 0,  3, 5, 4, 0, 0,   77,  6};
        tbl[3] = '{100, 1, 0, 0,  0, -1, 0, 2, 0, 100, 107, 4};
        tbl[4] = '{0,   2, 1, 0,  0, -1, 0, 5, 1, 1,   15,  4};

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check_idle("reset");

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N; i++) begin
                fx[i] = tbl[t].x_base + tbl[t].x_mul * DW'(i);
                fy[i] = tbl[t].y_base + tbl[t].y_mul * DW'(i);
            end
            s0 = start_cnt; w0 = wr_total; wait_cycles = 0;
            done_lat = tbl[t].dlat; stale_done = tbl[t].stale;
            stall_at = tbl[t].stall_at; stall_left = tbl[t].stall_len;
            ready_mode = 0;
            send_frame(tbl[t].gap);
            wait_drain();
            check("start_pulses", start_cnt - s0, 1);
            check("writes", wr_total - w0, N);
            check("first_out", got[0], tbl[t].exp_first);
            check("last_out", got[N-1], tbl[t].exp_last);
            check("latency", last_lat, tbl[t].exp_lat);
            check("stall_cycles", wait_cycles, tbl[t].stall_len);
            stale_done = 1'b0;
        end

        // Two frames back-to-back.
        s0 = start_cnt; w0 = wr_total; done_lat = 3;
        for (int i = 0; i < N; i++) begin fx[i] = DW'(i); fy[i] = DW'(10 * i); end
        send_frame(0);
        for (int i = 0; i < N; i++) begin fx[i] = DW'(100 + i); fy[i] = '0; end
        send_frame(0);
        wait_drain();
        check("b2b_starts", start_cnt - s0, 2);
        check("b2b_writes", wr_total - w0, 2 * N);
        check("b2b_first", got[0], 100);
        check("b2b_last", got[N-1], 107);

        // Reset while waiting for done.
        done_lat = 30;
        for (int i = 0; i < N; i++) begin fx[i] = DW'(i); fy[i] = 1; end
        send_frame(0);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_idle("rst_wait");
        exp_q.delete();
        s0 = start_cnt;
        tick(40);
        check("rst_wait_no_start", start_cnt - s0, 0);
        check("rst_wait_ready", in_ready, 1);

        // Reset while presenting a result.
        done_lat = 2; ready_mode = 2;
        send_frame(0);
        b = 0;
        while (!out_valid && b < 50) begin tick(1); b++; end
        check("out_valid_seen", out_valid, 1);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_idle("rst_out");
        exp_q.delete();
        ready_mode = 0;
        s0 = start_cnt;
        tick(40);
        check("rst_out_no_start", start_cnt - s0, 0);

        // Recovery frame, then randomized frames.
        s0 = start_cnt;
        for (int i = 0; i < N; i++) begin fx[i] = DW'(5 * i); fy[i] = DW'(7); end
        send_frame(0);
        wait_drain();
        check("recover_start", start_cnt - s0, 1);

        ready_mode = 1;
        s0 = start_cnt;
        for (int f = 0; f < 4; f++) begin
            done_lat = int'($urandom_range(2, 6));
            for (int i = 0; i < N; i++) begin fx[i] = $urandom; fy[i] = $urandom; end
            send_frame(-1);
        end
        wait_drain();
        check("rand_starts", start_cnt - s0, 4);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
